fpu_sign_minmax_pipe: RTL and testbench
=======================================

Name: fpu_sign_minmax_pipe

Overview:
Parametrised, pipelined successor to the combinational sign-injection unit. It executes the sign-injection ops (sgnj/sgnjn/sgnjx) and IEEE-754-2008 minNum/maxNum (fmin/fmax) on one floating-point format, selected by parameters. Defaults are Bfloat16. The block has a valid/ready handshake on both sides and sits between the FPU decode/issue stage and the FPU result-writeback arbiter.

Parameters:
Std, 15, MSB index of an operand (total width - 1); default Bfloat16.
Exp, 7, exponent width - 1.
Man, 6, mantissa width - 1. Constraint: Std == Exp + Man + 2. Elaboration fails otherwise.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_l  input  1  asynchronous, active-low reset.
in_valid  input  1  operand/op presented.
in_ready  output  1  block accepts when in_valid & in_ready at a clk edge.
op  input  6  one-hot-ish opcode: bit0 sgnj, bit1 sgnjn, bit2 sgnjx, bit3 fmin, bit4 fmax, bit5 fclass (only under macro).
IEEE_A  input  Std+1  operand A.
IEEE_B  input  Std+1  operand B.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result when out_valid & out_ready.
IEEE_out  output  Std+1  result.
nv_flag  output  1  invalid-operation exception, qualified by out_valid.

Behaviour:
- Reset (rst_l low, asynchronous): s1_valid = 0, s2_valid = 0, out_valid = 0, IEEE_out = 0, nv_flag = 0, in_ready = 0. in_ready is forced 0 while rst_l is low. Any in-flight ops are discarded and never emitted.
- Pipeline: S1 registers A, B and op. S2 computes the result and registers IEEE_out/nv_flag; out_valid = s2_valid.
- Latency: 2 clk edges from acceptance to out_valid, with out_ready high. Throughput is 1 op/cycle.
- s2_load = s1_valid & (~s2_valid | out_ready).
- s1_load = in_valid & in_ready.
- in_ready = rst_l & (~s1_valid | ~s2_valid | out_ready). This is a combinational path from out_ready; accepted.
- s2_valid clears when it is consumed without a reload. s1_valid clears when it is advanced without a reload.
- Stall: while out_valid & ~out_ready, IEEE_out and nv_flag hold stable. Ops are never dropped, duplicated or reordered.
- Op priority: the lowest set bit wins (bit0 highest priority). op == 0, or an unsupported bit: IEEE_out = 0, nv_flag = 0, still handshaken.
- sgnj: {B.sign, A[Std-1:0]}. sgnjn: {~B.sign, A[Std-1:0]}. sgnjx: {A.sign ^ B.sign, A[Std-1:0]}. There is no NaN processing and nv_flag = 0.
- Classification:
  - NaN = exp all ones & mantissa != 0.
  - sNaN = NaN & mantissa MSB == 0.
  - Canonical NaN = {0, all-ones exp, 1, zeros} (bf16: 16'h7FC0).
- fmin/fmax:
  - Both NaN: canonical NaN.
  - One NaN: the other operand.
  - Otherwise: the signed-ordered min/max, with -0 < +0.
  - Compare as sign-magnitude. Equal operands: return A.
  - nv_flag = 1 if either operand is an sNaN, else 0.
- Result width is Std+1 for all ops. No rounding is performed.

Optional Feature:
Macro FPU_SIGN_CLASSIFY_EN.
- Defined: op bit5 = fclass of IEEE_A. IEEE_out[9:0] is the RISC-V class mask: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN. Upper bits are 0 and nv_flag = 0. Requires Std >= 9.
- Undefined: op bit5 is treated as an unsupported op (result 0, nv_flag 0). Latency and handshake are identical in both builds.

Test Plan:
- sgnj A=16'h3F80, B=16'hC000 -> 16'hBF80. sgnjn same operands -> 16'h3F80. sgnjx A=16'hBF80, B=16'hC000 -> 16'h3F80. Each appears 2 cycles after acceptance, nv_flag 0.
- fmin A=16'h0000, B=16'h8000 -> 16'h8000. fmax with the same operands -> 16'h0000. fmax 16'h3F80 vs 16'hC000 -> 16'h3F80. nv_flag 0 throughout.
- fmin A=16'h7F81 (sNaN), B=16'h3F80 -> 16'h3F80, nv_flag 1. fmax 16'h7FC0 vs 16'h7FC0 -> 16'h7FC0, nv 0. fmin 16'h7F81 vs 16'h7F81 -> 16'h7FC0, nv 1.
- Backpressure: 3 back-to-back ops with out_ready low for 4 cycles. in_ready drops after 2 accepts, and out_valid/IEEE_out stay stable. After out_ready rises, results come out in order on consecutive cycles, with no loss or duplication.
- Reset mid-flight: rst_l low with 2 ops in S1/S2. out_valid, IEEE_out and nv_flag go to 0 immediately, without waiting for clk. After release, out_valid stays 0 until a new op is accepted.
- With FPU_SIGN_CLASSIFY_EN, fclass A=16'hFF80 -> 16'h0001 and A=16'h7F81 -> 16'h0100. Without the macro, op=6'b100000 -> 16'h0000.

Source files
------------

// File: rtl/fpu_sign_minmax_pipe_if.sv
// Operand/result handshake bundle for fpu_sign_minmax_pipe.
// Master is the issuing side; slave is the pipeline.
interface fpu_sign_minmax_pipe_if #(
  parameter int Std = 15
);
  logic           in_valid;
  logic           in_ready;
  logic [5:0]     op;
  logic [Std:0]   IEEE_A;
  logic [Std:0]   IEEE_B;
  logic           out_valid;
  logic           out_ready;
  logic [Std:0]   IEEE_out;
  logic           nv_flag;

  modport master (
    output in_valid, op, IEEE_A, IEEE_B, out_ready,
    input  in_ready, out_valid, IEEE_out, nv_flag
  );

  modport slave (
    input  in_valid, op, IEEE_A, IEEE_B, out_ready,
    output in_ready, out_valid, IEEE_out, nv_flag
  );
endinterface

// File: rtl/fpu_sign_minmax_pipe.sv
// Sign injection and minNum/maxNum (fclass under FPU_SIGN_CLASSIFY_EN), 2-stage pipe.
// Latency 2 edges from acceptance, 1 op/cycle.
// Backpressure: S2 holds while out_ready is low; in_ready drops once S1 and S2 are both full.
module fpu_sign_minmax_pipe #(
  parameter int Std = 15,
  parameter int Exp = 7,
  parameter int Man = 6
) (
  input  logic                      clk,
  input  logic                      rst_l,
  fpu_sign_minmax_pipe_if.slave     bus
);

  generate
    if (Std != Exp + Man + 2) begin : g_bad_cfg
      $error("fpu_sign_minmax_pipe: Std must equal Exp + Man + 2");
    end
`ifdef FPU_SIGN_CLASSIFY_EN
    if (Std < 9) begin : g_bad_cls
      $error("fpu_sign_minmax_pipe: fclass needs Std >= 9");
    end
`endif
  endgenerate

  localparam logic [Std:0] CANON_NAN = {1'b0, {(Exp+1){1'b1}}, 1'b1, {Man{1'b0}}};

  logic           r_s1_valid;
  logic           r_s2_valid;
  logic [Std:0]   r_a;
  logic [Std:0]   r_b;
  logic [5:0]     r_op;
  logic [Std:0]   r_out;
  logic           r_nv;

  logic           w_s1_load;
  logic           w_s2_load;
  logic [Std:0]   w_res;
  logic           w_nv;

  logic           w_a_sign, w_b_sign;
  logic [Exp:0]   w_a_exp, w_b_exp;
  logic [Man:0]   w_a_man, w_b_man;
  logic [Std-1:0] w_a_mag, w_b_mag;
  logic           w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic           w_a_lt_b, w_b_lt_a;

  assign w_s2_load    = r_s1_valid & (~r_s2_valid | bus.out_ready);
  assign w_s1_load    = bus.in_valid & bus.in_ready;
  // Combinational through out_ready so a full pipe can still accept while draining.
  assign bus.in_ready = rst_l & (~r_s1_valid | ~r_s2_valid | bus.out_ready);

  assign bus.out_valid = r_s2_valid;
  assign bus.IEEE_out  = r_out;
  assign bus.nv_flag   = r_nv;

  assign w_a_sign = r_a[Std];
  assign w_b_sign = r_b[Std];
  assign w_a_exp  = r_a[Std-1:Man+1];
  assign w_b_exp  = r_b[Std-1:Man+1];
  assign w_a_man  = r_a[Man:0];
  assign w_b_man  = r_b[Man:0];
  assign w_a_mag  = r_a[Std-1:0];
  assign w_b_mag  = r_b[Std-1:0];

  assign w_a_nan  = (&w_a_exp) & (|w_a_man);
  assign w_b_nan  = (&w_b_exp) & (|w_b_man);
  assign w_a_snan = w_a_nan & ~w_a_man[Man];
  assign w_b_snan = w_b_nan & ~w_b_man[Man];

  // Sign-magnitude ordering; differing signs put -0 below +0.
  always_comb begin
    w_a_lt_b = 1'b0;
    w_b_lt_a = 1'b0;
    if (w_a_sign != w_b_sign) begin
      w_a_lt_b = w_a_sign;
      w_b_lt_a = w_b_sign;
    end else if (!w_a_sign) begin
      w_a_lt_b = w_a_mag < w_b_mag;
      w_b_lt_a = w_b_mag < w_a_mag;
    end else begin
      w_a_lt_b = w_a_mag > w_b_mag;
      w_b_lt_a = w_b_mag > w_a_mag;
    end
  end

  always_comb begin
    w_res = '0;
    w_nv  = 1'b0;
    if (r_op[0]) begin
      w_res = {w_b_sign, w_a_mag};
    end else if (r_op[1]) begin
      w_res = {~w_b_sign, w_a_mag};
    end else if (r_op[2]) begin
      w_res = {w_a_sign ^ w_b_sign, w_a_mag};
    end else if (r_op[3] || r_op[4]) begin
      w_nv = w_a_snan | w_b_snan;
      if (w_a_nan && w_b_nan)
        w_res = CANON_NAN;
      else if (w_a_nan)
        w_res = r_b;
      else if (w_b_nan)
        w_res = r_a;
      else if (r_op[3])
        w_res = w_b_lt_a ? r_b : r_a;
      else
        w_res = w_a_lt_b ? r_b : r_a;
`ifdef FPU_SIGN_CLASSIFY_EN
    end else if (r_op[5]) begin
      w_res[0] =  w_a_sign & (&w_a_exp) & ~(|w_a_man);
      w_res[1] =  w_a_sign & ~(&w_a_exp) & (|w_a_exp);
      w_res[2] =  w_a_sign & ~(|w_a_exp) & (|w_a_man);
      w_res[3] =  w_a_sign & ~(|w_a_exp) & ~(|w_a_man);
      w_res[4] = ~w_a_sign & ~(|w_a_exp) & ~(|w_a_man);
      w_res[5] = ~w_a_sign & ~(|w_a_exp) & (|w_a_man);
      w_res[6] = ~w_a_sign & ~(&w_a_exp) & (|w_a_exp);
      w_res[7] = ~w_a_sign & (&w_a_exp) & ~(|w_a_man);
      w_res[8] = w_a_snan;
      w_res[9] = w_a_nan & w_a_man[Man];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_a        <= bus.IEEE_A;
      r_b        <= bus.IEEE_B;
      r_op       <= bus.op;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_nv       <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_out      <= w_res;
      r_nv       <= w_nv;
    end else if (r_s2_valid && bus.out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_sign_minmax_pipe.sv
// Directed bench for fpu_sign_minmax_pipe (bf16 defaults); inputs change and outputs
// are sampled on the falling clock edge.
module tb_fpu_sign_minmax_pipe;

  logic clk = 1'b0;
  logic rst_l;
  int   n_chk = 0;
  int   n_bad = 0;

  fpu_sign_minmax_pipe_if #(.Std(15)) bus();

  fpu_sign_minmax_pipe #(.Std(15), .Exp(7), .Man(6)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_SGNJ  = 6'b000001;
  localparam logic [5:0] OP_SGNJN = 6'b000010;
  localparam logic [5:0] OP_SGNJX = 6'b000100;
  localparam logic [5:0] OP_FMIN  = 6'b001000;
  localparam logic [5:0] OP_FMAX  = 6'b010000;
  localparam logic [5:0] OP_FCLS  = 6'b100000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left on a falling edge with out_ready high.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res, input logic exp_nv);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.IEEE_A   = a;
    bus.IEEE_B   = b;
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".early"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".vld"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".res"}, {16'd0, bus.IEEE_out}, {16'd0, exp_res});
    chk({tag, ".nv"},  {31'd0, bus.nv_flag}, {31'd0, exp_nv});
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".drain"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_l         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.IEEE_A    = '0;
    bus.IEEE_B    = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst.out",       {16'd0, bus.IEEE_out},  32'd0);
    chk("rst.nv",        {31'd0, bus.nv_flag},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    run_op("sgnj",      OP_SGNJ,  16'h3F80, 16'hC000, 16'hBF80, 1'b0);
    run_op("sgnjn",     OP_SGNJN, 16'h3F80, 16'hC000, 16'h3F80, 1'b0);
    run_op("sgnjx",     OP_SGNJX, 16'hBF80, 16'hC000, 16'h3F80, 1'b0);
    run_op("fmin_z",    OP_FMIN,  16'h0000, 16'h8000, 16'h8000, 1'b0);
    run_op("fmax_z",    OP_FMAX,  16'h0000, 16'h8000, 16'h0000, 1'b0);
    run_op("fmax_pn",   OP_FMAX,  16'h3F80, 16'hC000, 16'h3F80, 1'b0);
    run_op("fmin_neg",  OP_FMIN,  16'hC000, 16'hBF80, 16'hC000, 1'b0);
    run_op("fmin_snan", OP_FMIN,  16'h7F81, 16'h3F80, 16'h3F80, 1'b1);
    run_op("fmax_qnan", OP_FMAX,  16'h7FC0, 16'h7FC0, 16'h7FC0, 1'b0);
    run_op("fmin_2snan",OP_FMIN,  16'h7F81, 16'h7F81, 16'h7FC0, 1'b1);
    run_op("fmax_bq",   OP_FMAX,  16'h4000, 16'hFFC1, 16'h4000, 1'b0);
    run_op("op_zero",   6'b000000,16'h3F80, 16'hC000, 16'h0000, 1'b0);
    run_op("prio",      6'b011001,16'h3F80, 16'hC000, 16'hBF80, 1'b0);
    run_op("prio_mm",   6'b011000,16'h3F80, 16'hC000, 16'hC000, 1'b0);
`ifdef FPU_SIGN_CLASSIFY_EN
    run_op("fcls_ninf", OP_FCLS,  16'hFF80, 16'h0000, 16'h0001, 1'b0);
    run_op("fcls_snan", OP_FCLS,  16'h7F81, 16'h0000, 16'h0100, 1'b0);
`else
    run_op("fcls_off",  OP_FCLS,  16'hFF80, 16'h0000, 16'h0000, 1'b0);
`endif

    // Backpressure: three back-to-back ops, consumer stalled for four cycles.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op = OP_SGNJ; bus.IEEE_A = 16'h3F80; bus.IEEE_B = 16'hC000;
    chk("bp.acc1", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.op = OP_FMAX; bus.IEEE_A = 16'h3F80; bus.IEEE_B = 16'hC000;
    chk("bp.acc2", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.op = OP_FMIN; bus.IEEE_A = 16'h0000; bus.IEEE_B = 16'h8000;
    for (int i = 0; i < 4; i++) begin
      chk("bp.full",  {31'd0, bus.in_ready},  32'd0);
      chk("bp.vld",   {31'd0, bus.out_valid}, 32'd1);
      chk("bp.hold",  {16'd0, bus.IEEE_out},  32'h0000BF80);
      if (i < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.reopen", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.r2.vld", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.r2",     {16'd0, bus.IEEE_out},  32'h00003F80);
    @(posedge clk);
    @(negedge clk);
    chk("bp.r3.vld", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.r3",     {16'd0, bus.IEEE_out},  32'h00008000);
    @(posedge clk);
    @(negedge clk);
    chk("bp.empty",  {31'd0, bus.out_valid}, 32'd0);

    // Reset with one op in each stage.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op = OP_FMIN; bus.IEEE_A = 16'h7F81; bus.IEEE_B = 16'h3F80;
    @(posedge clk);
    @(negedge clk);
    bus.op = OP_SGNJ; bus.IEEE_A = 16'h3F80; bus.IEEE_B = 16'hC000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mr.pre.vld", {31'd0, bus.out_valid}, 32'd1);
    chk("mr.pre.nv",  {31'd0, bus.nv_flag},   32'd1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("mr.vld",      {31'd0, bus.out_valid}, 32'd0);
    chk("mr.out",      {16'd0, bus.IEEE_out},  32'd0);
    chk("mr.nv",       {31'd0, bus.nv_flag},   32'd0);
    chk("mr.in_ready", {31'd0, bus.in_ready},  32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("mr.quiet", {31'd0, bus.out_valid}, 32'd0);
    end
    run_op("mr.after", OP_SGNJN, 16'hBF80, 16'h3F80, 16'hBF80, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
